csa_accumulator_seq: RTL and testbench
======================================

# csa_accumulator_seq

Sequential, handshaked successor to the combinational carry-save accumulator. It sums a stream of beats, each carrying LANES signed or unsigned INW-bit results from the systolic array. The running total is held in redundant carry-save form, so there is no carry propagation on the accumulate path. When a group ends, one carry-propagate resolve stage produces a binary OUTW-bit total. It sits between the array output columns and the output buffer, one instance per column.

## Interface
- ARRAYSIZE, 16, guard bits; also the width of the beat counter
- INW, 16, width of one lane result
- LANES, 2, results compressed per beat (≥1)
- OUTW, ARRAYSIZE+INW (derived localparam), accumulator and output width
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_data  in  LANES*INW  lane k at bits [k*INW +: INW]
- in_signed  in  1  per beat: 1 = lanes are two's complement, 0 = unsigned
- in_last  in  1  beat closes the current group
- out_valid  out  1  resolved total valid
- out_ready  in  1  consumer accepts the total
- out_sum  out  OUTW  binary total of the group, modulo 2^OUTW
- out_count  out  ARRAYSIZE  beats in the group, saturating at all-ones
- out_sat  out  1  beat counter saturated during the group

## Operation
- Internal registers:
  - sum_r, carry_r: OUTW bits each, carry-save pair
  - cnt_r: ARRAYSIZE bits
  - sat_r: 1 bit
  - state: ACC, RESOLVE or OUT
- Lane extension to OUTW:
  - in_signed=1: sign-extend each lane.
  - in_signed=0: zero-extend each lane.
- Accepted beat in ACC:
  - {sum_r, carry_r} ← 3:2 CSA chain of sum_r, carry_r and the LANES extended lanes.
  - The chain uses LANES CSA levels; each carry is shifted left 1 and bits above OUTW-1 are dropped.
  - The invariant sum_r + carry_r ≡ running total (mod 2^OUTW) must hold after every beat.
- Beat counting:
  - cnt_r increments on every accepted beat and saturates at 2^ARRAYSIZE−1.
  - sat_r sets when an increment is attempted at the saturated value.
- State transitions:
  - ACC: in_ready=1. An accepted beat with in_last=1 moves to RESOLVE.
  - RESOLVE: in_ready=0. Load out_sum ← sum_r + carry_r (OUTW-bit CPA, truncated), out_count ← cnt_r, out_sat ← sat_r. Clear sum_r, carry_r, cnt_r and sat_r. Next state is OUT.
  - OUT: out_valid=1 and in_ready=0. out_sum, out_count and out_sat stay stable until out_ready=1. On out_ready=1, move to ACC.
- A beat with in_valid=0 changes nothing. Inputs are ignored whenever in_ready=0.
- The single-beat group case (first beat also has in_last=1) is legal; out_count=1.
- in_signed may differ between beats of the same group; each beat is extended on its own.

## Timing
- Reset (rst=1 at a clock edge, any state, including mid-group or while out_valid is high):
  - state→ACC
  - sum_r, carry_r, cnt_r, sat_r → 0
  - out_valid=0, out_sum=0, out_count=0, out_sat=0
  - in_ready=1 in the first cycle after reset is released
- rst has priority over every other event in the same cycle. An in-flight group is discarded with no output.
- Latency: last beat accepted at edge t → RESOLVE during cycle t..t+1 → out_valid=1 from edge t+1. out_sum is registered.
- Throughput:
  - 1 beat/cycle within a group.
  - Minimum of 2 dead cycles between groups (RESOLVE plus one OUT cycle when out_ready=1 immediately).
- Handshake:
  - in_ready depends only on state (registered). It is not combinational from out_ready.
  - out_valid must not drop before acceptance.
- Overflow: the total wraps modulo 2^OUTW and no flag is raised for it. out_sat flags counter saturation only.

## Test plan
- Reset and signed group:
  - Stimulus: reset, then LANES=2 signed beats (3,−5) and (−1,7, last).
  - Required: out_sum=4, out_count=2, out_sat=0; out_valid rises exactly 1 edge after the last beat is accepted.
- Unsigned extremes:
  - Stimulus: one unsigned beat (0xFFFF,0xFFFF, last).
  - Required: out_sum=0x0001FFFE, out_count=1.
- Mixed signedness:
  - Stimulus: beats (0x8000 signed, 0x8000 signed), then (0x8000 unsigned, 0, last).
  - Required: out_sum = −65536 + 32768 = 0xFFFF8000 (OUTW=32).
- Backpressure and idle beats:
  - Stimulus: in_valid toggled with gaps mid-group; out_ready held 0 for 5 cycles after out_valid.
  - Required: out_sum and out_count stable throughout, in_ready=0 for the whole wait, accumulation resumes only after acceptance.
- Wrap and saturation:
  - Stimulus: ARRAYSIZE=2, INW=4, LANES=1; 5 signed beats of 7.
  - Required: out_sum = 35 mod 64 = 35, out_count=3, out_sat=1.
- Mid-group reset:
  - Stimulus: rst asserted after 2 beats.
  - Required: no out_valid; the next group of (1,1, last) gives out_sum=2, out_count=1.

Source files
------------

// File: rtl/csa_accumulator_seq_if.sv
// Beat/result handshake bundle for the carry-save accumulator.
// The master side feeds beats and consumes totals. The slave side is the accumulator.
interface csa_accumulator_seq_if #(
    parameter int ARRAYSIZE = 16,
    parameter int INW       = 16,
    parameter int LANES     = 2
);
    localparam int OUTW = ARRAYSIZE + INW;

    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*INW-1:0]   in_data;
    logic                   in_signed;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUTW-1:0]        out_sum;
    logic [ARRAYSIZE-1:0]   out_count;
    logic                   out_sat;

    modport master (
        output in_valid, in_data, in_signed, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_signed, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_sat
    );
endinterface

// File: rtl/csa_accumulator_seq.sv
// Handshaked carry-save accumulator: sums beats of LANES lane results in redundant form.
// One carry-propagate add per group turns the redundant total into binary.
module csa_accumulator_seq #(
    parameter int ARRAYSIZE = 16,
    parameter int INW       = 16,
    parameter int LANES     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    csa_accumulator_seq_if.slave     bus,
    output logic [1:0]               dbg_state
);
    localparam int OUTW = ARRAYSIZE + INW;

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // Ready depends only on the registered state. Once valid is raised, it stays high
    // and its payload stays stable until the transfer happens.
    typedef enum logic [1:0] {
        ACC     = 2'd0,
        RESOLVE = 2'd1,
        OUT     = 2'd2
    } state_t;

    state_t state, state_next;

    logic [OUTW-1:0]      sum_r, carry_r;
    logic [ARRAYSIZE-1:0] cnt_r;
    logic                 sat_r;
    logic [OUTW-1:0]      out_sum_r;
    logic [ARRAYSIZE-1:0] out_count_r;
    logic                 out_sat_r;

    logic in_ready_c, out_valid_c;
    logic beat;

    assign beat = bus.in_valid && in_ready_c;

    // The redundant pair enters at level 0. Each lane adds one 3:2 level.
    logic [OUTW-1:0] chain_s [LANES+1];
    logic [OUTW-1:0] chain_c [LANES+1];

    assign chain_s[0] = sum_r;
    assign chain_c[0] = carry_r;

    for (genvar k = 0; k < LANES; k++) begin : g_csa
        logic [INW-1:0]  lane;
        logic [OUTW-1:0] ext;
        logic [OUTW-1:0] maj;

        assign lane = bus.in_data[k*INW +: INW];
        assign ext  = bus.in_signed ? {{(OUTW-INW){lane[INW-1]}}, lane}
                                    : {{(OUTW-INW){1'b0}}, lane};
        assign maj  = (chain_s[k] & chain_c[k]) | (chain_s[k] & ext) | (chain_c[k] & ext);

        assign chain_s[k+1] = chain_s[k] ^ chain_c[k] ^ ext;
        // The carry weight is doubled. A carry out of the top bit is dropped, so the sum wraps mod 2^OUTW.
        assign chain_c[k+1] = {maj[OUTW-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            ACC: begin
                in_ready_c = 1'b1;
                if (bus.in_valid && bus.in_last) begin
                    state_next = RESOLVE;
                end
            end
            RESOLVE: begin
                state_next = OUT;
            end
            OUT: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_next = ACC;
                end
            end
            default: begin
                state_next = ACC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r       <= '0;
            carry_r     <= '0;
            cnt_r       <= '0;
            sat_r       <= 1'b0;
            out_sum_r   <= '0;
            out_count_r <= '0;
            out_sat_r   <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (beat) begin
                        sum_r   <= chain_s[LANES];
                        carry_r <= chain_c[LANES];
                        if (cnt_r == {ARRAYSIZE{1'b1}}) begin
                            sat_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + ARRAYSIZE'(1);
                        end
                    end
                end
                RESOLVE: begin
                    out_sum_r   <= sum_r + carry_r;
                    out_count_r <= cnt_r;
                    out_sat_r   <= sat_r;
                    sum_r       <= '0;
                    carry_r     <= '0;
                    cnt_r       <= '0;
                    sat_r       <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_sum   = out_sum_r;
    assign bus.out_count = out_count_r;
    assign bus.out_sat   = out_sat_r;
    assign dbg_state     = state;
endmodule

// File: tb/tb_csa_accumulator_seq.sv
// Directed bench for csa_accumulator_seq: a table of groups plus hand-written
// sequences for backpressure, mid-group reset and counter saturation.
module tb_csa_accumulator_seq;
    localparam int AS = 16;
    localparam int IW = 16;
    localparam int LN = 2;
    localparam int OW = AS + IW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    csa_accumulator_seq_if #(.ARRAYSIZE(AS), .INW(IW), .LANES(LN)) bus ();
    logic [1:0] dbg_state;
    csa_accumulator_seq #(.ARRAYSIZE(AS), .INW(IW), .LANES(LN)) dut (
        .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
    );

    // Small instance: a 2-bit counter and a 6-bit total, so saturation is reached quickly
    csa_accumulator_seq_if #(.ARRAYSIZE(2), .INW(4), .LANES(1)) bus_s ();
    logic [1:0] dbg_state_s;
    csa_accumulator_seq #(.ARRAYSIZE(2), .INW(4), .LANES(1)) dut_s (
        .clk(clk), .rst(rst), .bus(bus_s), .dbg_state(dbg_state_s)
    );

    typedef struct packed {
        logic [2:0]       n;
        logic [3:0]       sgn;
        logic [3:0][31:0] data;
        logic [31:0]      exp_sum;
        logic [15:0]      exp_cnt;
        logic             exp_sat;
    } vec_t;

    vec_t vecs [5];
    logic [48:0] exp_q [$];
    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic s, input logic l);
        int waited = 0;
        logic acc = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_signed = s;
        bus.in_last   = l;
        while (!acc && waited < 20) begin
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (!acc) check("beat_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called #1 after the edge that accepted the last beat of a group
    task automatic finish_group(input string tag);
        logic [48:0] e;
        check({tag, "_resolve_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_resolve_ready"}, 64'(bus.in_ready), 64'd0);
        check({tag, "_resolve_state"}, 64'(dbg_state), 64'd1);
        @(posedge clk);
        #1;
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_exp_q_empty"}, 64'd0, 64'd1);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        check({tag, "_sum"}, 64'(bus.out_sum), 64'(e[48:17]));
        check({tag, "_count"}, 64'(bus.out_count), 64'(e[16:1]));
        check({tag, "_sat"}, 64'(bus.out_sat), 64'(e[0]));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_back_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_back_valid"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        logic [31:0] held_sum;
        logic [15:0] held_cnt;

        // Lane 1 sits in the upper half of each beat word
        vecs[0] = '{n: 3'd2, sgn: 4'b0011, data: {32'h0, 32'h0, 32'h0007_FFFF, 32'hFFFB_0003},
                    exp_sum: 32'd4, exp_cnt: 16'd2, exp_sat: 1'b0};
        vecs[1] = '{n: 3'd1, sgn: 4'b0000, data: {32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF},
                    exp_sum: 32'h0001_FFFE, exp_cnt: 16'd1, exp_sat: 1'b0};
        vecs[2] = '{n: 3'd2, sgn: 4'b0001, data: {32'h0, 32'h0, 32'h0000_8000, 32'h8000_8000},
                    exp_sum: 32'hFFFF_8000, exp_cnt: 16'd2, exp_sat: 1'b0};
        vecs[3] = '{n: 3'd3, sgn: 4'b0000, data: {32'h0, 32'h0006_0005, 32'h0004_0003, 32'h0002_0001},
                    exp_sum: 32'd21, exp_cnt: 16'd3, exp_sat: 1'b0};
        vecs[4] = '{n: 3'd1, sgn: 4'b0001, data: {32'h0, 32'h0, 32'h0, 32'h8000_8000},
                    exp_sum: 32'hFFFF_0000, exp_cnt: 16'd1, exp_sat: 1'b0};

        bus.in_valid = 0; bus.in_data = '0; bus.in_signed = 0; bus.in_last = 0; bus.out_ready = 0;
        bus_s.in_valid = 0; bus_s.in_data = '0; bus_s.in_signed = 0; bus_s.in_last = 0; bus_s.out_ready = 0;

        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_sum", 64'(bus.out_sum), 64'd0);
        check("rst_out_count", 64'(bus.out_count), 64'd0);
        check("rst_out_sat", 64'(bus.out_sat), 64'd0);

        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({vecs[i].exp_sum, vecs[i].exp_cnt, vecs[i].exp_sat});
            for (int b = 0; b < int'(vecs[i].n); b++) begin
                send_beat(vecs[i].data[b], vecs[i].sgn[b], b == int'(vecs[i].n) - 1);
            end
            finish_group($sformatf("vec%0d", i));
        end

        // Gaps between beats, then 5 cycles of backpressure with junk beats offered
        send_beat({16'd10, 16'd20}, 1'b0, 1'b0);
        idle(2);
        send_beat({16'd30, 16'd40}, 1'b0, 1'b0);
        idle(1);
        send_beat({16'hFFFF, 16'd0}, 1'b1, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = {16'd7, 16'd7};
        idle(1);
        held_sum = 32'd99;
        held_cnt = 16'd3;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_valid%0d", c), 64'(bus.out_valid), 64'd1);
            check($sformatf("bp_ready%0d", c), 64'(bus.in_ready), 64'd0);
            check($sformatf("bp_sum%0d", c), 64'(bus.out_sum), 64'(held_sum));
            check($sformatf("bp_count%0d", c), 64'(bus.out_count), 64'(held_cnt));
            idle(1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        idle(1);
        bus.out_ready = 1'b0;
        check("bp_released_ready", 64'(bus.in_ready), 64'd1);
        exp_q.push_back({32'd2, 16'd1, 1'b0});
        send_beat({16'd1, 16'd1}, 1'b0, 1'b1);
        finish_group("bp_next");

        // Reset after two beats: the open group is discarded
        send_beat({16'd100, 16'd100}, 1'b0, 1'b0);
        send_beat({16'd5, 16'd5}, 1'b0, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("mr_in_ready", 64'(bus.in_ready), 64'd1);
        check("mr_out_sum", 64'(bus.out_sum), 64'd0);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("mr_no_valid%0d", c), 64'(bus.out_valid), 64'd0);
            idle(1);
        end
        exp_q.push_back({32'd2, 16'd1, 1'b0});
        send_beat({16'd1, 16'd1}, 1'b0, 1'b1);
        finish_group("mr_next");

        // 5 signed beats of 7 on the small instance: counter saturates at 3
        bus_s.in_valid  = 1'b1;
        bus_s.in_data   = 4'd7;
        bus_s.in_signed = 1'b1;
        for (int b = 0; b < 5; b++) begin
            bus_s.in_last = (b == 4);
            check($sformatf("sat_ready%0d", b), 64'(bus_s.in_ready), 64'd1);
            idle(1);
        end
        bus_s.in_valid = 1'b0;
        bus_s.in_last  = 1'b0;
        check("sat_resolve_valid", 64'(bus_s.out_valid), 64'd0);
        idle(1);
        check("sat_out_valid", 64'(bus_s.out_valid), 64'd1);
        check("sat_sum", 64'(bus_s.out_sum), 64'd35);
        check("sat_count", 64'(bus_s.out_count), 64'd3);
        check("sat_flag", 64'(bus_s.out_sat), 64'd1);
        bus_s.out_ready = 1'b1;
        idle(1);
        bus_s.out_ready = 1'b0;
        check("sat_back_ready", 64'(bus_s.in_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
